serial_link_vc_credit_scheduler: RTL and testbench
==================================================

# serial_link_vc_credit_scheduler

Credit-aware scheduler that shares the single AXIS link of the serial-link NoC bridge between `NumVc` virtual channels (VCs), for example the req and rsp channels. It tracks the remote credits available to each VC and the credits owed back to the remote side for each VC. Each cycle it grants one data-eligible VC and selects which VC's owed credits to piggyback on the outgoing packet. When no data is eligible and owed credits have built up, it issues a credit-only packet. Its registered output drives the header and credit fields of the outgoing AXIS packet.

## Interface
- `NumVc`, 2, number of virtual channels sharing the link.
- `NumCred`, 8, per-VC receive-buffer depth on each side; also the reset value of the transmit credits.
- `ForceSendThresh`, `NumCred-4`, owed-credit count at which a credit-only packet is forced.
- `CredW`, `$clog2(NumCred+1)`, credit field width (derived).
- `IdxW`, `$clog2(NumVc)` (minimum 1), VC index width (derived).
- Clocking and reset: one clock; reset is asynchronous and active-high.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  asynchronous active-high reset.
- `vc_valid_i`  in  NumVc  VC k has a flit ready to transmit.
- `vc_ready_o`  out  NumVc  one-hot grant; the flit of VC k is consumed this cycle.
- `buf_pop_i`  in  NumVc  local receive buffer of VC k released one entry; that VC owes one credit.
- `cred_rcvd_valid_i`  in  1  an incoming packet carrying credits was accepted this cycle.
- `cred_rcvd_vc_i`  in  IdxW  VC the incoming credits belong to.
- `cred_rcvd_i`  in  CredW  number of incoming credits.
- `out_valid_o`  out  1  output packet valid.
- `out_ready_i`  in  1  output packet accepted.
- `out_data_vld_o`  out  1  1 = data packet; 0 = credit-only packet.
- `out_data_vc_o`  out  IdxW  VC of the data flit; 0 when `out_data_vld_o`=0.
- `out_cred_vc_o`  out  IdxW  VC the credit field belongs to.
- `out_cred_o`  out  CredW  credits returned to the remote side.
- `tx_cred_o`  out  NumVc*CredW  current transmit credits per VC (debug).

## Operation
- State per VC:
  - `tx_cred[k]`: reset `NumCred`.
  - `owed[k]`: reset 0.
- Other state:
  - round-robin pointer: reset 0.
  - output register: reset `out_valid_o`=0, all output fields 0.
- `load` = `!out_valid_o | out_ready_i`. The register can only accept a new packet when `load`=1.
- Eligibility: VC k is eligible iff `vc_valid_i[k]` and `tx_cred[k]>0`. A VC with zero credits is never granted.
- Data winner: the first eligible VC at or after the round-robin pointer. After a grant the pointer moves to winner+1 mod `NumVc`.
- Credit source: the VC with the largest `owed`; ties go to the lowest index.
- Packet decision when `load`=1:
  - Any VC eligible: data packet. `vc_ready_o[winner]`=1, `out_data_vld_o`=1, credit field = `owed[src]`, `out_cred_vc_o`=src.
  - No VC eligible and `owed[src] >= ForceSendThresh`: credit-only packet, `out_data_vld_o`=0.
  - Otherwise: `out_valid_o` falls to 0 (or stays 0).
- Counter updates on each load (same edge):
  - `tx_cred[winner]` decrements by 1.
  - `owed[src]` becomes `buf_pop_i[src]`, i.e. cleared, but a pop in the same cycle survives.
- `owed[k]` increments on `buf_pop_i[k]`. It saturates at `NumCred`; exceeding that is an assertion error.
- `tx_cred[v]` adds `cred_rcvd_i` when `cred_rcvd_valid_i` and `v=cred_rcvd_vc_i`.
  - Simultaneous add and decrement on the same VC apply the net change.
  - The result saturates at `NumCred`; overflow is an assertion error.
- A zero-valued credit field is legal on data packets.
- `vc_ready_o` is all-zero whenever `load`=0 or no VC is eligible.

## Timing
- Grant is combinational in the load cycle. The packet appears on the outputs from the next cycle: one cycle latency.
- Throughput: one packet per cycle while `out_ready_i`=1.
- Outputs are registered. All `out_*` fields are stable while `out_valid_o & !out_ready_i`.
- `vc_ready_o` depends combinationally on `vc_valid_i`, `out_valid_o` and `out_ready_i`, never on the data.
- A credit received in cycle t makes the VC eligible in cycle t+1.
- A pop in cycle t is included in a credit field loaded no earlier than cycle t+1.
- Reset asserted mid-transfer immediately clears `out_valid_o` and `vc_ready_o`. Counters return to their reset values; an in-flight packet is dropped.

## Test plan
- After reset: `tx_cred_o` = 8 for every VC and `out_valid_o`=0. Hold `vc_valid_i`=2'b01 and `out_ready_i`=1 for 10 cycles → exactly 8 grants to VC0, then `vc_ready_o` stays 0.
- `vc_valid_i`=2'b11, `out_ready_i`=1 → grants alternate VC0, VC1, VC0, …; each `tx_cred` drops by 1 per own grant.
- Pulse `buf_pop_i[1]` 4 times with no data → one credit-only packet with `out_cred_vc_o`=1, `out_cred_o`=4; `owed[1]` returns to 0.
- `out_ready_i`=0 for 5 cycles while valid → outputs unchanged and `vc_ready_o`=0; release → the held packet is accepted, then the next grant follows.
- Drain VC0 to 0 credits, then in one cycle apply `cred_rcvd_valid_i` with VC0 and 3 credits → `tx_cred[0]`=3 and VC0 is granted the next cycle.
- `owed` = {2,2} → credit field picks VC0; a pop on VC0 in the load cycle leaves `owed[0]`=1.

Source files
------------

// File: rtl/serial_link_vc_credit_scheduler_if.sv
// Outgoing packet stream of the VC credit scheduler.
// Carries one registered packet per handshake: header (data/credit-only flag,
// data VC) and the piggybacked credit field (credit VC, credit count).
//   valid    : packet valid (driven by the scheduler)
//   ready    : packet accepted (driven by the link serializer)
//   data_vld : 1 = data packet, 0 = credit-only packet
//   data_vc  : VC of the data flit, 0 on credit-only packets
//   cred_vc  : VC the credit field belongs to
//   cred     : credits returned to the remote side
interface serial_link_vc_credit_scheduler_if #(
  parameter int NumVc   = 2,
  parameter int NumCred = 8,
  parameter int CredW   = $clog2(NumCred + 1),
  parameter int IdxW    = (NumVc > 1) ? $clog2(NumVc) : 1
);
  logic             valid;
  logic             ready;
  logic             data_vld;
  logic [IdxW-1:0]  data_vc;
  logic [IdxW-1:0]  cred_vc;
  logic [CredW-1:0] cred;

  modport master (output valid, data_vld, data_vc, cred_vc, cred, input ready);
  modport slave  (input valid, data_vld, data_vc, cred_vc, cred, output ready);
endinterface

// File: rtl/serial_link_vc_credit_scheduler.sv
// Credit-aware scheduler sharing one serial link between NumVc virtual
// channels. Tracks remote (transmit) credits and credits owed back per VC,
// grants one data-eligible VC per cycle round-robin, piggybacks the largest
// owed credit count on each packet and forces credit-only packets when owed
// credits pile up with no data to send.
// Ports:
//   clk_i, rst_i       : clock, asynchronous active-high reset
//   vc_valid_i         : VC k has a flit ready
//   vc_ready_o         : one-hot grant, flit of VC k consumed this cycle
//   buf_pop_i          : local receive buffer of VC k freed one entry
//   cred_rcvd_valid_i  : incoming credits valid this cycle
//   cred_rcvd_vc_i     : VC of the incoming credits
//   cred_rcvd_i        : incoming credit count
//   pkt                : registered outgoing packet stream (master side)
//   tx_cred_o          : packed transmit credits per VC, VC0 in the LSBs
module serial_link_vc_credit_scheduler #(
  parameter int NumVc           = 2,
  parameter int NumCred         = 8,
  parameter int ForceSendThresh = NumCred - 4,
  parameter int CredW           = $clog2(NumCred + 1),
  parameter int IdxW            = (NumVc > 1) ? $clog2(NumVc) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NumVc-1:0]        vc_valid_i,
  output logic [NumVc-1:0]        vc_ready_o,
  input  logic [NumVc-1:0]        buf_pop_i,
  input  logic                    cred_rcvd_valid_i,
  input  logic [IdxW-1:0]         cred_rcvd_vc_i,
  input  logic [CredW-1:0]        cred_rcvd_i,
  serial_link_vc_credit_scheduler_if.master pkt,
  output logic [NumVc*CredW-1:0]  tx_cred_o
);

  logic [CredW-1:0] tx_cred_q [NumVc];
  logic [CredW-1:0] tx_cred_d [NumVc];
  logic [CredW-1:0] owed_q    [NumVc];
  logic [CredW-1:0] owed_d    [NumVc];
  logic [CredW:0]   tx_sum    [NumVc];
  logic [NumVc-1:0] tx_ovf;
  logic [NumVc-1:0] owed_ovf;
  logic [IdxW-1:0]  rr_ptr_q;
  logic [IdxW-1:0]  next_ptr;

  logic             load;
  logic [NumVc-1:0] eligible;
  logic             any_elig;
  logic [IdxW-1:0]  winner;
  logic [IdxW-1:0]  src;
  logic [CredW-1:0] best;
  logic [IdxW:0]    rot;
  logic [IdxW-1:0]  cand;
  logic             send_data;
  logic             send_cred;
  logic             pkt_load;

  assign load = !pkt.valid || pkt.ready;

  // A VC without remote credits can never be granted, even if it has data.
  always_comb begin
    eligible = '0;
    for (int k = 0; k < NumVc; k++) begin
      eligible[k] = vc_valid_i[k] && (tx_cred_q[k] != '0);
    end
  end

  // Round-robin search: walk downward so the last hit is the first eligible
  // VC at or after the pointer.
  always_comb begin
    winner   = '0;
    any_elig = 1'b0;
    rot      = '0;
    cand     = '0;
    for (int i = NumVc - 1; i >= 0; i--) begin
      rot = {1'b0, rr_ptr_q} + (IdxW+1)'(i);
      if (rot >= (IdxW+1)'(NumVc)) begin
        rot = rot - (IdxW+1)'(NumVc);
      end
      cand = rot[IdxW-1:0];
      if (eligible[cand]) begin
        winner   = cand;
        any_elig = 1'b1;
      end
    end
  end

  assign next_ptr = (winner == IdxW'(NumVc - 1)) ? '0 : winner + 1'b1;

  // Credit source: strict greater-than keeps ties on the lowest index.
  always_comb begin
    src  = '0;
    best = owed_q[0];
    for (int k = 1; k < NumVc; k++) begin
      if (owed_q[k] > best) begin
        best = owed_q[k];
        src  = IdxW'(k);
      end
    end
  end

  assign send_data = load && any_elig;
  assign send_cred = load && !any_elig && (owed_q[src] >= CredW'(ForceSendThresh));
  assign pkt_load  = send_data || send_cred;

  // Grant is held low during reset so an in-flight transfer is dropped cleanly.
  always_comb begin
    vc_ready_o = '0;
    if (send_data && !rst_i) begin
      vc_ready_o[winner] = 1'b1;
    end
  end

  // Next-state counters: received credits and the grant decrement are
  // combined so a simultaneous add and consume on one VC nets out. Owed
  // credits of the source VC are cleared on a packet load, but a pop in
  // the same cycle must not be lost.
  always_comb begin
    tx_ovf   = '0;
    owed_ovf = '0;
    for (int k = 0; k < NumVc; k++) begin
      tx_sum[k] = {1'b0, tx_cred_q[k]};
      if (cred_rcvd_valid_i && (cred_rcvd_vc_i == IdxW'(k))) begin
        tx_sum[k] = tx_sum[k] + {1'b0, cred_rcvd_i};
      end
      if (send_data && (winner == IdxW'(k))) begin
        tx_sum[k] = tx_sum[k] - 1'b1;
      end
      if (tx_sum[k] > (CredW+1)'(NumCred)) begin
        tx_ovf[k]    = 1'b1;
        tx_cred_d[k] = CredW'(NumCred);
      end else begin
        tx_cred_d[k] = tx_sum[k][CredW-1:0];
      end

      owed_d[k] = owed_q[k];
      if (pkt_load && (src == IdxW'(k))) begin
        owed_d[k] = {{(CredW-1){1'b0}}, buf_pop_i[k]};
      end else if (buf_pop_i[k]) begin
        if (owed_q[k] == CredW'(NumCred)) begin
          owed_ovf[k] = 1'b1;
        end else begin
          owed_d[k] = owed_q[k] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    tx_cred_o = '0;
    for (int k = 0; k < NumVc; k++) begin
      tx_cred_o[k*CredW +: CredW] = tx_cred_q[k];
    end
  end

  // Counter state, round-robin pointer and the output packet register. The
  // packet register only changes on load, which keeps every field stable
  // while the link stalls.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < NumVc; k++) begin
        tx_cred_q[k] <= CredW'(NumCred);
        owed_q[k]    <= '0;
      end
      rr_ptr_q     <= '0;
      pkt.valid    <= 1'b0;
      pkt.data_vld <= 1'b0;
      pkt.data_vc  <= '0;
      pkt.cred_vc  <= '0;
      pkt.cred     <= '0;
    end else begin
      for (int k = 0; k < NumVc; k++) begin
        tx_cred_q[k] <= tx_cred_d[k];
        owed_q[k]    <= owed_d[k];
      end
      if (send_data) begin
        rr_ptr_q <= next_ptr;
      end
      if (load) begin
        pkt.valid    <= pkt_load;
        pkt.data_vld <= send_data;
        pkt.data_vc  <= send_data ? winner : '0;
        pkt.cred_vc  <= pkt_load ? src : '0;
        pkt.cred     <= pkt_load ? owed_q[src] : '0;
      end
    end
  end

`ifndef SYNTHESIS
  a_tx_cred_overflow: assert property (@(posedge clk_i) disable iff (rst_i) tx_ovf == '0);
  a_owed_overflow:    assert property (@(posedge clk_i) disable iff (rst_i) owed_ovf == '0);
`endif

endmodule

// File: tb/tb_serial_link_vc_credit_scheduler.sv
// Self-checking bench for serial_link_vc_credit_scheduler (NumVc=2, NumCred=8).
// Each scenario task pushes the packets it expects onto a scoreboard queue;
// every accepted output packet is popped and compared as it leaves the DUT.
module tb_serial_link_vc_credit_scheduler;
  localparam int NumVc   = 2;
  localparam int NumCred = 8;
  localparam int CredW   = 4;
  localparam int IdxW    = 1;

  typedef struct packed {
    logic             data_vld;
    logic [IdxW-1:0]  data_vc;
    logic [IdxW-1:0]  cred_vc;
    logic [CredW-1:0] cred;
  } pkt_t;

  logic                   clk;
  logic                   rst;
  logic [NumVc-1:0]       vc_valid;
  logic [NumVc-1:0]       vc_ready;
  logic [NumVc-1:0]       buf_pop;
  logic                   cred_valid;
  logic [IdxW-1:0]        cred_vc;
  logic [CredW-1:0]       cred_val;
  logic [NumVc*CredW-1:0] tx_cred;

  serial_link_vc_credit_scheduler_if #(.NumVc(NumVc), .NumCred(NumCred)) link ();

  serial_link_vc_credit_scheduler #(.NumVc(NumVc), .NumCred(NumCred)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .vc_valid_i        (vc_valid),
    .vc_ready_o        (vc_ready),
    .buf_pop_i         (buf_pop),
    .cred_rcvd_valid_i (cred_valid),
    .cred_rcvd_vc_i    (cred_vc),
    .cred_rcvd_i       (cred_val),
    .pkt               (link.master),
    .tx_cred_o         (tx_cred)
  );

  int   total = 0;
  int   bad = 0;
  int   grants0 = 0;
  int   grants1 = 0;
  logic [NumVc-1:0] seen_ready;
  pkt_t exp_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic pkt_t mk(input logic v, input int dvc, input int cvc, input int c);
    pkt_t p;
    p.data_vld = v;
    p.data_vc  = IdxW'(dvc);
    p.cred_vc  = IdxW'(cvc);
    p.cred     = CredW'(c);
    return p;
  endfunction

  // One clock: sample at the falling edge (grant and accepted packet), then
  // return just after the rising edge where the next inputs are driven.
  task automatic cycle();
    pkt_t got;
    pkt_t exp;
    @(negedge clk);
    seen_ready = vc_ready;
    if (vc_ready[0]) grants0++;
    if (vc_ready[1]) grants1++;
    if (!rst && link.valid && link.ready) begin
      got = {link.data_vld, link.data_vc, link.cred_vc, link.cred};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpected_pkt got vld=%0b dvc=%0d cvc=%0d cred=%0d required none",
                 got.data_vld, got.data_vc, got.cred_vc, got.cred);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          bad++;
          $display("[TB] FAIL pkt got vld=%0b dvc=%0d cvc=%0d cred=%0d required vld=%0b dvc=%0d cvc=%0d cred=%0d",
                   got.data_vld, got.data_vc, got.cred_vc, got.cred,
                   exp.data_vld, exp.data_vc, exp.cred_vc, exp.cred);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    vc_valid   = '0;
    buf_pop    = '0;
    cred_valid = 1'b0;
    cred_vc    = '0;
    cred_val   = '0;
    link.ready = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (tx_cred !== 8'h88) begin
      bad++;
      $display("[TB] FAIL reset_tx_cred got=%h required=88", tx_cred);
    end
    total++;
    if (link.valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_valid got=%b required=0", link.valid);
    end
    total++;
    if ({link.data_vld, link.data_vc, link.cred_vc, link.cred} !== 7'd0) begin
      bad++;
      $display("[TB] FAIL reset_fields got=%h required=0",
               {link.data_vld, link.data_vc, link.cred_vc, link.cred});
    end
  endtask

  task automatic test_single_vc();
    vc_valid   = 2'b01;
    link.ready = 1'b1;
    grants0 = 0;
    grants1 = 0;
    repeat (8) exp_q.push_back(mk(1'b1, 0, 0, 0));
    repeat (10) cycle();
    vc_valid = 2'b00;
    cycle();
    total++;
    if (grants0 != 8 || grants1 != 0) begin
      bad++;
      $display("[TB] FAIL single_grants got=%0d/%0d required=8/0", grants0, grants1);
    end
    total++;
    if (tx_cred !== 8'h80) begin
      bad++;
      $display("[TB] FAIL single_tx_cred got=%h required=80", tx_cred);
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL single_pending got=%0d required=0", exp_q.size());
    end
  endtask

  task automatic test_credit_refill();
    vc_valid   = 2'b01;
    cred_valid = 1'b1;
    cred_vc    = 1'b0;
    cred_val   = 4'd3;
    cycle();
    cred_valid = 1'b0;
    total++;
    if (seen_ready !== 2'b00) begin
      bad++;
      $display("[TB] FAIL refill_no_grant got=%b required=00", seen_ready);
    end
    total++;
    if (tx_cred !== 8'h83) begin
      bad++;
      $display("[TB] FAIL refill_tx_cred got=%h required=83", tx_cred);
    end
    repeat (3) exp_q.push_back(mk(1'b1, 0, 0, 0));
    grants0 = 0;
    cycle();
    total++;
    if (seen_ready !== 2'b01) begin
      bad++;
      $display("[TB] FAIL refill_grant got=%b required=01", seen_ready);
    end
    repeat (4) cycle();
    vc_valid = 2'b00;
    cycle();
    total++;
    if (grants0 != 3 || tx_cred !== 8'h80 || exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL refill_drain got grants=%0d tx=%h pending=%0d required 3/80/0",
               grants0, tx_cred, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_r;
    do_reset();
    vc_valid   = 2'b11;
    link.ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(mk(1'b1, i % 2, 0, 0));
      exp_r = (i % 2 == 0) ? 2'b01 : 2'b10;
      cycle();
      total++;
      if (seen_ready !== exp_r) begin
        bad++;
        $display("[TB] FAIL rr_grant_%0d got=%b required=%b", i, seen_ready, exp_r);
      end
    end
    vc_valid = 2'b00;
    cycle();
    total++;
    if (tx_cred !== 8'h55 || exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL rr_final got tx=%h pending=%0d required 55/0", tx_cred, exp_q.size());
    end
  endtask

  task automatic test_credit_only();
    do_reset();
    link.ready = 1'b1;
    buf_pop    = 2'b10;
    repeat (4) cycle();
    buf_pop = 2'b00;
    exp_q.push_back(mk(1'b0, 0, 1, 4));
    repeat (3) cycle();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL cred_only_pending got=%0d required=0", exp_q.size());
    end
    vc_valid = 2'b01;
    exp_q.push_back(mk(1'b1, 0, 0, 0));
    cycle();
    vc_valid = 2'b00;
    cycle();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL cred_only_cleared got pending=%0d required=0", exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    vc_valid   = 2'b11;
    link.ready = 1'b1;
    exp_q.push_back(mk(1'b1, 0, 0, 0));
    cycle();
    link.ready = 1'b0;
    buf_pop    = 2'b10;
    for (int i = 0; i < 5; i++) begin
      cycle();
      buf_pop = 2'b00;
      total++;
      if (seen_ready !== 2'b00 ||
          {link.valid, link.data_vld, link.data_vc, link.cred_vc, link.cred} !== 8'b1100_0000) begin
        bad++;
        $display("[TB] FAIL stall_%0d got ready=%b out=%b required ready=00 out=11000000", i,
                 seen_ready, {link.valid, link.data_vld, link.data_vc, link.cred_vc, link.cred});
      end
    end
    link.ready = 1'b1;
    exp_q.push_back(mk(1'b1, 1, 1, 1));
    cycle();
    total++;
    if (seen_ready !== 2'b10) begin
      bad++;
      $display("[TB] FAIL release_grant got=%b required=10", seen_ready);
    end
    vc_valid = 2'b00;
    cycle();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL release_pending got=%0d required=0", exp_q.size());
    end
  endtask

  task automatic test_owed_tie();
    do_reset();
    link.ready = 1'b1;
    buf_pop    = 2'b11;
    repeat (2) cycle();
    buf_pop  = 2'b01;
    vc_valid = 2'b01;
    exp_q.push_back(mk(1'b1, 0, 0, 2));
    cycle();
    buf_pop = 2'b00;
    exp_q.push_back(mk(1'b1, 0, 1, 2));
    cycle();
    exp_q.push_back(mk(1'b1, 0, 0, 1));
    cycle();
    vc_valid = 2'b00;
    cycle();
    total++;
    if (tx_cred !== 8'h85 || exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL tie_final got tx=%h pending=%0d required 85/0", tx_cred, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    vc_valid   = 2'b01;
    link.ready = 1'b0;
    cycle();
    cycle();
    total++;
    if (link.valid !== 1'b1) begin
      bad++;
      $display("[TB] FAIL mid_held got=%b required=1", link.valid);
    end
    rst = 1'b1;
    #1;
    total++;
    if (link.valid !== 1'b0 || vc_ready !== 2'b00 || tx_cred !== 8'h88) begin
      bad++;
      $display("[TB] FAIL mid_reset got valid=%b ready=%b tx=%h required 0/00/88",
               link.valid, vc_ready, tx_cred);
    end
    vc_valid   = 2'b00;
    link.ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) cycle();
    total++;
    if (exp_q.size() != 0 || link.valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL mid_after got pending=%0d valid=%b required 0/0", exp_q.size(), link.valid);
    end
  endtask

  initial begin
    test_reset();
    test_single_vc();
    test_credit_refill();
    test_back_to_back();
    test_credit_only();
    test_backpressure();
    test_owed_tie();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
